// File: rtl/msix_engine.sv
// MSI-X vector table, pending bit array and message-issue engine behind a BAR decode.
// Define MSIX_ADDR_CHECK_EN to refuse vectors whose message address is not DWORD aligned.
module msix_engine #(
  parameter int          NUM_MSIX          = 8,
  parameter int          MSIX_TABLE_BIR    = 0,
  parameter logic [31:0] MSIX_TABLE_OFFSET = 32'h2000,
  parameter int          MSIX_PBA_BIR      = 0,
  parameter logic [31:0] MSIX_PBA_OFFSET   = 32'h3000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         bar_addr,
  input  logic [2:0]          bar_index,
  input  logic [31:0]         bar_wr_data,
  input  logic                bar_wr_en,
  input  logic [3:0]          bar_wr_be,
  input  logic                bar_rd_en,
  output logic [31:0]         bar_rd_data,
  output logic                bar_access_match,
  input  logic                msix_enable,
  input  logic                msix_function_mask,
  input  logic [NUM_MSIX-1:0] irq_req,
  output logic                msg_valid,
  output logic [63:0]         msg_addr,
  output logic [31:0]         msg_data,
  output logic [10:0]         msg_vector,
  input  logic                msg_ready,
  output logic                msix_cfg_err
);

  localparam int PBA_DWORDS = (NUM_MSIX + 31) / 32;
  localparam int PBA_QW_DW  = ((PBA_DWORDS + 1) / 2) * 2;
  localparam int PBA_BITS   = PBA_QW_DW * 32;
  localparam int IW         = (NUM_MSIX > 1) ? $clog2(NUM_MSIX) : 1;
  localparam int PW         = $clog2(PBA_QW_DW);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t state, state_nx;

  logic [31:0]         addr_lo [NUM_MSIX];
  logic [31:0]         addr_hi [NUM_MSIX];
  logic [31:0]         data_tbl [NUM_MSIX];
  logic [NUM_MSIX-1:0] mask_bits;
  logic [NUM_MSIX-1:0] pending;
  logic [NUM_MSIX-1:0] eligible;
  logic [NUM_MSIX-1:0] clr_vec;
  logic [PBA_BITS-1:0] pend_pad;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       msg_idx;
  logic [IW:0]         pick;
  logic                load, accept;

  logic [31:0]   tbl_off, pba_off;
  logic          table_hit, pba_hit;
  logic [IW-1:0] tbl_ent;
  logic [1:0]    tbl_dw;
  logic [PW-1:0] pba_dw;
  logic [31:0]   rd_mux;
  logic          unused_ok;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Lowest requester at or above start wins; otherwise wrap to the lowest overall.
  function automatic logic [IW:0] rr_pick(input logic [NUM_MSIX-1:0] req, input logic [IW-1:0] start);
    logic          hi_hit, lo_hit;
    logic [IW-1:0] hi_idx, lo_idx;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_MSIX - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(start)) begin
          hi_hit = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    if (hi_hit) return {1'b1, hi_idx};
    return {lo_hit, lo_idx};
  endfunction

  assign tbl_off   = bar_addr - MSIX_TABLE_OFFSET;
  assign pba_off   = bar_addr - MSIX_PBA_OFFSET;
  assign table_hit = (bar_index == 3'(MSIX_TABLE_BIR)) && (bar_addr >= MSIX_TABLE_OFFSET) &&
                     (tbl_off < 32'(16 * NUM_MSIX));
  assign pba_hit   = (bar_index == 3'(MSIX_PBA_BIR)) && (bar_addr >= MSIX_PBA_OFFSET) &&
                     (pba_off < 32'(4 * PBA_QW_DW));
  assign bar_access_match = table_hit || pba_hit;
  assign tbl_ent   = tbl_off[IW+3:4];
  assign tbl_dw    = tbl_off[3:2];
  assign pba_dw    = pba_off[PW+1:2];
  assign unused_ok = ^{tbl_off, pba_off, bar_addr[1:0]};

  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_MSIX-1:0] = pending;
  end

  always_comb begin
    rd_mux = '0;
    if (table_hit) begin
      case (tbl_dw)
        2'd0:    rd_mux = addr_lo[tbl_ent];
        2'd1:    rd_mux = addr_hi[tbl_ent];
        2'd2:    rd_mux = data_tbl[tbl_ent];
        default: rd_mux = {31'b0, mask_bits[tbl_ent]};
      endcase
    end else if (pba_hit) begin
      rd_mux = pend_pad[{pba_dw, 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bar_rd_data <= '0;
    else if (bar_rd_en) bar_rd_data <= rd_mux;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_MSIX; n++) begin
        addr_lo[n]  <= '0;
        addr_hi[n]  <= '0;
        data_tbl[n] <= '0;
      end
      mask_bits <= '1;
    end else if (bar_wr_en && table_hit) begin
      case (tbl_dw)
        2'd0:    addr_lo[tbl_ent]  <= merge_be(addr_lo[tbl_ent], bar_wr_data, bar_wr_be);
        2'd1:    addr_hi[tbl_ent]  <= merge_be(addr_hi[tbl_ent], bar_wr_data, bar_wr_be);
        2'd2:    data_tbl[tbl_ent] <= merge_be(data_tbl[tbl_ent], bar_wr_data, bar_wr_be);
        default: if (bar_wr_be[0]) mask_bits[tbl_ent] <= bar_wr_data[0];
      endcase
    end
  end

  // A request arriving with the acceptance of the same vector survives the clear.
  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[msg_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else pending <= (pending & ~clr_vec) | irq_req;
  end

`ifdef MSIX_ADDR_CHECK_EN
  logic [NUM_MSIX-1:0] addr_ok;
  logic [IW:0]         raw_pick;

  always_comb begin
    addr_ok = '0;
    for (int n = 0; n < NUM_MSIX; n++) addr_ok[n] = (addr_lo[n][1:0] == 2'b00);
  end

  assign eligible = pending & ~mask_bits & addr_ok & {NUM_MSIX{msix_enable & ~msix_function_mask}};
  assign raw_pick = rr_pick(pending & ~mask_bits & {NUM_MSIX{msix_enable & ~msix_function_mask}}, ptr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) msix_cfg_err <= 1'b0;
    else if (state == S_IDLE && raw_pick[IW] && !addr_ok[raw_pick[IW-1:0]]) msix_cfg_err <= 1'b1;
  end
`else
  assign eligible     = pending & ~mask_bits & {NUM_MSIX{msix_enable & ~msix_function_mask}};
  assign msix_cfg_err = 1'b0;
`endif

  assign pick = rr_pick(eligible, ptr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick[IW]) begin
          load     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      default: begin
        if (msg_ready) begin
          accept   = 1'b1;
          state_nx = S_IDLE;
        end
      end
    endcase
  end

  assign msg_valid  = (state == S_ISSUE);
  assign msg_vector = 11'(msg_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_addr <= '0;
      msg_data <= '0;
      msg_idx  <= '0;
      ptr      <= '0;
    end else begin
      if (load) begin
        msg_addr <= {addr_hi[pick[IW-1:0]], addr_lo[pick[IW-1:0]]};
        msg_data <= data_tbl[pick[IW-1:0]];
        msg_idx  <= pick[IW-1:0];
      end
      if (accept) ptr <= (msg_idx == IW'(NUM_MSIX - 1)) ? '0 : msg_idx + 1'b1;
    end
  end

endmodule

// File: doc/msix_engine.md
Name: msix_engine

Overview:
Parametrised MSI-X table, PBA and message-issue engine. Supports up to 2048 vectors, 64-bit message addresses and a multi-DWORD PBA. Sits behind the BAR decode: the host programs table entries over the BAR interface, and per-vector interrupt requests become MSI-X memory-write messages via a valid/ready port to the TLP transmit path.

Parameters:
NUM_MSIX, 8, vector count, 1..2048
MSIX_TABLE_BIR, 0, BAR index holding the table
MSIX_TABLE_OFFSET, 32'h2000, table byte offset in that BAR, 16-byte aligned
MSIX_PBA_BIR, 0, BAR index holding the PBA
MSIX_PBA_OFFSET, 32'h3000, PBA byte offset, 8-byte aligned
PBA_DWORDS, derived = ceil(NUM_MSIX/32), not overridable

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
bar_addr  in  32  byte offset within BAR; [1:0] ignored
bar_index  in  3  BAR number of the access
bar_wr_data  in  32  write data
bar_wr_en  in  1  write strobe, one cycle per DWORD
bar_wr_be  in  4  byte enables
bar_rd_en  in  1  read strobe
bar_rd_data  out  32  read data, registered
bar_access_match  out  1  combinational hit on table or PBA range
msix_enable  in  1  MSI-X Enable, from config space
msix_function_mask  in  1  Function Mask, from config space
irq_req  in  NUM_MSIX  per-vector request pulses
msg_valid  out  1  message presented
msg_addr  out  64  message address
msg_data  out  32  message data
msg_vector  out  11  vector number
msg_ready  in  1  transmit path accepts message
msix_cfg_err  out  1  sticky misconfiguration flag (see Optional Feature)

Behaviour:
- Entry n at TABLE_OFFSET+16n: DW0 addr[31:0], DW1 addr[63:32], DW2 data, DW3 control (bit0 mask; bits 31:1 read 0, writes ignored).
- Reset: addr/data 0, every mask bit 1, PBA 0, bar_rd_data 0, msg_valid 0, msg_addr/data/vector 0, msix_cfg_err 0, FSM IDLE, arbiter pointer 0.
- Writes honour bar_wr_be per byte. PBA writes are ignored. Accesses outside both ranges, or with a BIR mismatch: no effect, read returns 0.
- Read: bar_rd_data is valid the cycle after bar_rd_en and holds until the next read. PBA DW k returns pending[32k+31:32k]; bits past NUM_MSIX read 0.
- irq_req[n] sets pending[n] the next cycle, in every state including enable=0 and masked.
- Eligible(n) = pending[n] & !mask[n] & msix_enable & !msix_function_mask.
- FSM IDLE: if any vector is eligible, pick by round-robin starting at pointer. Latch its addr/data/vector into the msg regs, assert msg_valid and go to ISSUE. Arbitration takes 1 cycle: request at cycle t gives msg_valid at t+2 at the earliest.
- FSM ISSUE: msg_* are held stable. No retraction, even if the vector is masked, the function is masked or MSI-X is disabled meanwhile. On msg_valid & msg_ready: clear pending[vector], set pointer = vector+1 mod NUM_MSIX, return to IDLE. One cycle of IDLE is required between messages.
- irq_req[n] in the same cycle as acceptance of vector n: pending stays 1 (a new event is held).
- Host rewrite of a presented entry during ISSUE does not alter the msg regs.
- Unmask of a pending vector causes issue under the normal rules.
- reset_n asserted mid-ISSUE: the message is dropped and all state returns to reset values immediately.

Optional Feature:
- Macro MSIX_ADDR_CHECK_EN.
- Defined: a vector whose addr[1:0] != 0 is never selected. Its pending bit is held, and msix_cfg_err sets the cycle it would otherwise have been selected; it clears only on reset.
- Undefined: no check, msix_cfg_err is tied 0, and addr[1:0] is forwarded as written.

Test Plan:
- Write entry 0 with DW0=FEDCBA98, DW1=00000001, DW2=12345678, DW3=0, then read back each DWORD -> identical values one cycle after bar_rd_en. Fresh entry 5 DW3 reads 00000001.
- enable=1, pulse irq_req[0] -> msg_valid 2 cycles later with addr=00000001FEDCBA98, data=12345678, vector=0. Hold msg_ready=0 for 5 cycles -> outputs stable. Assert ready -> PBA DW0 reads 0.
- Vector 3 masked, pulse irq_req[3] -> no msg_valid, PBA DW0=00000008. Unmask -> message for vector 3, then PBA DW0=0.
- NUM_MSIX=40, function_mask=1, pulse vectors 0, 33, 39 -> PBA DW0=00000001 and DW1=00000082. Clear function_mask -> issue order 0, 33, 39.
- Pulse irq_req[2] in the same cycle vector 2 is accepted -> a second message for vector 2 follows.
- MSIX_ADDR_CHECK_EN defined, entry 1 addr=00000002, pulse irq_req[1] -> no message, msix_cfg_err=1, PBA bit1 set.
